// File: rtl/lane_serializer_if.sv
// rtl/lane_serializer_if.sv - lane-side and serial-side handshake bundle for lane_serializer
interface lane_serializer_if #(
   parameter int LANES = 4,
   parameter int WIDTH = 8
);
   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

   logic [LANES*WIDTH-1:0] dataIn;
   logic [LANES-1:0]       validIn;
   logic [LANES-1:0]       readyIn;
   logic [WIDTH-1:0]       dataOut;
   logic                   validOut;
   logic [LW-1:0]          laneOut;
   logic                   readyOut;

   modport master (
      output dataIn, validIn, readyOut,
      input  readyIn, dataOut, validOut, laneOut
   );

   modport slave (
      input  dataIn, validIn, readyOut,
      output readyIn, dataOut, validOut, laneOut
   );
endinterface

// File: rtl/lane_serializer.sv
// rtl/lane_serializer.sv - N-lane to 1-lane word serializer, round-robin or fixed-slot TDM
// Optional saturating word/bubble counters: define LANE_SER_STATS_EN.
module lane_serializer #(
   parameter int LANES    = 4,
   parameter int WIDTH    = 8,
   parameter int TDM_MODE = 0,
   parameter int CNT_W    = 16
) (
   input  logic             clk_1,
   input  logic             reset,
`ifdef LANE_SER_STATS_EN
   output logic [CNT_W-1:0] wordCount,
   output logic [CNT_W-1:0] bubbleCount,
`endif
   lane_serializer_if.slave bus
);
   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [LW-1:0] LAST = LW'(LANES - 1);

   if (LANES < 2 || LANES > 16 || WIDTH < 1 || CNT_W < 1) begin : g_param_check
      $error("lane_serializer: parameter out of range");
   end

   logic [WIDTH-1:0] hold_q [LANES];
   logic [LANES-1:0] hold_vld_q, hold_vld_d;
   logic [LW-1:0]    ptr_q, ptr_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic [LW-1:0]    lane_q, lane_d;

   logic             ld;
   logic             found;
   logic [LW-1:0]    grant;
   logic [LW-1:0]    cand;
   int               idx;
   logic [LANES-1:0] drain;
   logic [LANES-1:0] accept;

   function automatic logic [LW-1:0] next_slot(input logic [LW-1:0] s);
      return (s == LAST) ? '0 : s + LW'(1);
   endfunction

   assign ld = ~valid_q | bus.readyOut;

   // Mode 0 searches from ptr for the first held lane; TDM simply offers the ptr slot.
   always_comb begin
      found = 1'b0;
      grant = ptr_q;
      cand  = ptr_q;
      idx   = 0;
      if (TDM_MODE != 0) begin
         found = hold_vld_q[ptr_q];
      end else begin
         for (int k = 0; k < LANES; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= LANES) idx = idx - LANES;
            cand = LW'(idx);
            if (!found && hold_vld_q[cand]) begin
               found = 1'b1;
               grant = cand;
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         drain[i] = ld && found && (grant == LW'(i));
      end
   end

   assign bus.readyIn = ~hold_vld_q | drain;
   assign accept      = bus.validIn & bus.readyIn;
   assign hold_vld_d  = (hold_vld_q & ~drain) | accept;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      lane_d  = lane_q;
      ptr_d   = ptr_q;
      if (ld) begin
         if (TDM_MODE != 0) begin
            valid_d = found;
            lane_d  = ptr_q;
            data_d  = hold_q[ptr_q];
            ptr_d   = next_slot(ptr_q);
         end else if (found) begin
            valid_d = 1'b1;
            lane_d  = grant;
            data_d  = hold_q[grant];
            ptr_d   = next_slot(grant);
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_1 or posedge reset) begin
      if (reset) begin
         hold_vld_q <= '0;
         ptr_q      <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         lane_q     <= '0;
         for (int i = 0; i < LANES; i++) hold_q[i] <= '0;
      end else begin
         hold_vld_q <= hold_vld_d;
         ptr_q      <= ptr_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         lane_q     <= lane_d;
         for (int i = 0; i < LANES; i++) begin
            if (accept[i]) hold_q[i] <= bus.dataIn[i*WIDTH +: WIDTH];
         end
      end
   end

   assign bus.dataOut  = data_q;
   assign bus.validOut = valid_q;
   assign bus.laneOut  = lane_q;

`ifdef LANE_SER_STATS_EN
   logic [CNT_W-1:0] word_cnt_q, bubble_cnt_q;

   always_ff @(posedge clk_1 or posedge reset) begin
      if (reset) begin
         word_cnt_q   <= '0;
         bubble_cnt_q <= '0;
      end else begin
         if (valid_q && bus.readyOut && (word_cnt_q != '1)) word_cnt_q <= word_cnt_q + CNT_W'(1);
         if (ld && !valid_d && (bubble_cnt_q != '1)) bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      end
   end

   assign wordCount   = word_cnt_q;
   assign bubbleCount = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_lane_serializer.sv
// tb/tb_lane_serializer.sv - scoreboard bench for lane_serializer (mode 0 x4, TDM x4, mode 0 x3)
module tb_lane_serializer;
   logic clk_1 = 1'b0;
   logic reset;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk_1 = ~clk_1;

   lane_serializer_if #(.LANES(4), .WIDTH(8)) if0 ();
   lane_serializer_if #(.LANES(4), .WIDTH(8)) if1 ();
   lane_serializer_if #(.LANES(3), .WIDTH(8)) if2 ();

`ifdef LANE_SER_STATS_EN
   logic [15:0] wc0, bc0, wc1, bc1, wc2, bc2;
`endif

   lane_serializer #(.LANES(4), .WIDTH(8), .TDM_MODE(0), .CNT_W(16)) u0 (
      .clk_1(clk_1), .reset(reset),
`ifdef LANE_SER_STATS_EN
      .wordCount(wc0), .bubbleCount(bc0),
`endif
      .bus(if0)
   );

   lane_serializer #(.LANES(4), .WIDTH(8), .TDM_MODE(1), .CNT_W(16)) u1 (
      .clk_1(clk_1), .reset(reset),
`ifdef LANE_SER_STATS_EN
      .wordCount(wc1), .bubbleCount(bc1),
`endif
      .bus(if1)
   );

   lane_serializer #(.LANES(3), .WIDTH(8), .TDM_MODE(0), .CNT_W(16)) u2 (
      .clk_1(clk_1), .reset(reset),
`ifdef LANE_SER_STATS_EN
      .wordCount(wc2), .bubbleCount(bc2),
`endif
      .bus(if2)
   );

   typedef struct packed {
      logic [3:0] lane;
      logic [7:0] data;
   } item_t;

   item_t      q0[$], q1[$], q2[$];
   logic [7:0] burst [4] = '{8'hFF, 8'hEE, 8'hDD, 8'hCC};

   function automatic item_t mk(input logic [3:0] l, input logic [7:0] d);
      item_t r;
      r.lane = l;
      r.data = d;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   always @(negedge clk_1) begin : mon0
      item_t e;
      if (!reset && if0.validOut && if0.readyOut) begin
         chk("u0_expected_present", 32'(q0.size() != 0), 32'd1);
         if (q0.size() != 0) begin
            e = q0.pop_front();
            chk("u0_lane", 32'(if0.laneOut), 32'(e.lane));
            chk("u0_data", 32'(if0.dataOut), 32'(e.data));
         end
      end
   end

   always @(negedge clk_1) begin : mon1
      item_t e;
      if (!reset && if1.validOut && if1.readyOut) begin
         chk("u1_expected_present", 32'(q1.size() != 0), 32'd1);
         if (q1.size() != 0) begin
            e = q1.pop_front();
            chk("u1_lane", 32'(if1.laneOut), 32'(e.lane));
            chk("u1_data", 32'(if1.dataOut), 32'(e.data));
         end
      end
   end

   always @(negedge clk_1) begin : mon2
      item_t e;
      if (!reset && if2.validOut && if2.readyOut) begin
         chk("u2_expected_present", 32'(q2.size() != 0), 32'd1);
         if (q2.size() != 0) begin
            e = q2.pop_front();
            chk("u2_lane", 32'(if2.laneOut), 32'(e.lane));
            chk("u2_data", 32'(if2.dataOut), 32'(e.data));
         end
      end
   end

   task automatic drive_in(input int which, input logic [31:0] words, input logic [3:0] v);
      if (which == 0) begin
         if0.dataIn  = words;
         if0.validIn = v;
      end else begin
         if2.dataIn  = words[23:0];
         if2.validIn = v[2:0];
      end
   endtask

   // Holds each lane's valid until that lane has been accepted.
   task automatic offer(input int which, input bit align, input logic [3:0] mask,
                        input logic [31:0] words);
      logic [3:0] pend, rdy;
      if (align) begin
         @(posedge clk_1);
         #1;
      end
      pend = mask;
      drive_in(which, words, pend);
      for (int c = 0; c < 40 && pend != 4'd0; c++) begin
         @(negedge clk_1);
         rdy = (which == 0) ? if0.readyIn : {1'b0, if2.readyIn};
         @(posedge clk_1);
         #1;
         pend = pend & ~rdy;
         drive_in(which, words, pend);
      end
      chk("offer_accepted", 32'(pend), 32'd0);
   endtask

   task automatic wait_drain();
      int c = 0;
      while ((q0.size() + q1.size() + q2.size()) != 0 && c < 60) begin
         @(negedge clk_1);
         c++;
      end
      chk("drain_complete", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
      repeat (2) @(negedge clk_1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, required normal finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      if0.validIn = '1; if0.dataIn = 32'hA5A5_A5A5; if0.readyOut = 1'b1;
      if1.validIn = '1; if1.dataIn = 32'h0;         if1.readyOut = 1'b1;
      if2.validIn = '1; if2.dataIn = 24'h0;         if2.readyOut = 1'b1;

      repeat (3) @(posedge clk_1);
      @(negedge clk_1);
      chk("rst_readyIn", 32'(if0.readyIn), 32'hF);
      chk("rst_validOut", 32'(if0.validOut), 32'd0);
      chk("rst_dataOut", 32'(if0.dataOut), 32'd0);
      chk("rst_laneOut", 32'(if0.laneOut), 32'd0);
      chk("rst_tdm_readyIn", 32'(if1.readyIn), 32'hF);
      chk("rst_l3_readyIn", 32'(if2.readyIn), 32'h7);

      @(posedge clk_1);
      #1;
      reset = 1'b0;
      if0.validIn = '0;
      if2.validIn = '0;
      if1.dataIn  = 32'h8800_BB00;
      if1.validIn = 4'b1010;
      q1.push_back(mk(4'd1, 8'hBB));
      q1.push_back(mk(4'd3, 8'h88));
      chk("release_readyIn", 32'(if0.readyIn), 32'hF);
      chk("release_validOut", 32'(if0.validOut), 32'd0);

      // TDM: slot 0 bubble, lane 1 word, slot 2 bubble, lane 3 word
      @(posedge clk_1);
      #1;
      if1.validIn = '0;
      for (int s = 0; s < 4; s++) begin
         @(negedge clk_1);
         chk("tdm_validOut", 32'(if1.validOut), 32'(s % 2));
         chk("tdm_laneOut", 32'(if1.laneOut), 32'(s));
      end
`ifdef LANE_SER_STATS_EN
      chk("tdm_bubbleCount", 32'(bc1), 32'd2);
      @(negedge clk_1);
      chk("tdm_wordCount", 32'(wc1), 32'd2);
`endif

      for (int k = 0; k < 4; k++) q0.push_back(mk(4'(k), burst[k]));
      offer(0, 1'b1, 4'hF, 32'hCCDD_EEFF);
      @(negedge clk_1);
      chk("burst_latency_validOut", 32'(if0.validOut), 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_1);
         chk("burst_validOut", 32'(if0.validOut), 32'd1);
         chk("burst_dataOut", 32'(if0.dataOut), 32'(burst[k]));
         chk("burst_laneOut", 32'(if0.laneOut), 32'(k));
      end
      @(negedge clk_1);
      chk("burst_end_validOut", 32'(if0.validOut), 32'd0);

      q0.push_back(mk(4'd2, 8'h77));
      offer(0, 1'b1, 4'b0100, 32'h0077_0000);
      @(negedge clk_1);
      chk("skip_latency_validOut", 32'(if0.validOut), 32'd0);
      @(negedge clk_1);
      chk("skip_validOut", 32'(if0.validOut), 32'd1);
      chk("skip_dataOut", 32'(if0.dataOut), 32'h77);
      chk("skip_laneOut", 32'(if0.laneOut), 32'd2);
      // ptr is now 3, so lane 0 wins over lane 2
      q0.push_back(mk(4'd0, 8'h11));
      q0.push_back(mk(4'd2, 8'h22));
      offer(0, 1'b1, 4'b0101, 32'h0022_0011);
      wait_drain();

      // Backpressure: first word latched from lane 3 (ptr=3), then frozen for 4 edges
      q0.push_back(mk(4'd3, 8'h13));
      q0.push_back(mk(4'd0, 8'h10));
      q0.push_back(mk(4'd1, 8'h11));
      q0.push_back(mk(4'd2, 8'h12));
      q0.push_back(mk(4'd3, 8'h23));
      q0.push_back(mk(4'd0, 8'h20));
      q0.push_back(mk(4'd1, 8'h21));
      q0.push_back(mk(4'd2, 8'h22));
      @(posedge clk_1);
      #1;
      if0.readyOut = 1'b0;
      fork
         begin
            offer(0, 1'b0, 4'hF, 32'h1312_1110);
            offer(0, 1'b0, 4'hF, 32'h2322_2120);
         end
         begin
            @(posedge clk_1);
            @(negedge clk_1);
            chk("bp_readyIn_fill", 32'(if0.readyIn), 32'h8);
            for (int c = 0; c < 3; c++) begin
               @(negedge clk_1);
               chk("bp_validOut", 32'(if0.validOut), 32'd1);
               chk("bp_dataOut", 32'(if0.dataOut), 32'h13);
               chk("bp_readyIn_full", 32'(if0.readyIn), 32'h0);
            end
            @(posedge clk_1);
            #1;
            if0.readyOut = 1'b1;
            @(negedge clk_1);
            chk("bp_release_dataOut", 32'(if0.dataOut), 32'h13);
            chk("bp_release_laneOut", 32'(if0.laneOut), 32'd3);
         end
      join
      wait_drain();

      // Mid-stream reset with one word in the output stage and two held
      @(posedge clk_1);
      #1;
      if0.readyOut = 1'b0;
      offer(0, 1'b0, 4'b0111, 32'h0033_3231);
      @(posedge clk_1);
      #1;
      chk("mid_pre_validOut", 32'(if0.validOut), 32'd1);
      chk("mid_pre_dataOut", 32'(if0.dataOut), 32'h31);
      reset = 1'b1;
      #1;
      chk("mid_rst_validOut", 32'(if0.validOut), 32'd0);
      chk("mid_rst_dataOut", 32'(if0.dataOut), 32'd0);
      chk("mid_rst_readyIn", 32'(if0.readyIn), 32'hF);
      repeat (2) @(posedge clk_1);
      #1;
      reset = 1'b0;
      if0.readyOut = 1'b1;
      q0.push_back(mk(4'd1, 8'h44));
      offer(0, 1'b1, 4'b0010, 32'h0000_4400);
      wait_drain();
      chk("mid_after_validOut", 32'(if0.validOut), 32'd0);

      // Three lanes: ptr wraps 2 -> 0, so lane 1 precedes lane 2 next time
      q2.push_back(mk(4'd0, 8'h50));
      q2.push_back(mk(4'd1, 8'h51));
      q2.push_back(mk(4'd2, 8'h52));
      offer(2, 1'b1, 4'b0111, 32'h0052_5150);
      wait_drain();
      q2.push_back(mk(4'd1, 8'h61));
      q2.push_back(mk(4'd2, 8'h62));
      offer(2, 1'b1, 4'b0110, 32'h0062_6100);
      wait_drain();
      chk("l3_end_validOut", 32'(if2.validOut), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
